// File: rtl/bzmusic_seq.sv
// bzmusic_seq: buzzer music sequencer walking a per-song note ROM segment with pause, loop, rests and end marker
module bzmusic_seq #(
   parameter int SEL_W    = 2,
   parameter int ADDR_W   = 8,
   parameter int NOTE_W   = 5,
   parameter int BEAT_W   = 4,
   parameter int UNIT_CYC = 12500000,
   parameter int GAP_CYC  = 500000,
   parameter int CNT_W    = 24
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en_i,
   input  logic              pause_i,
   input  logic              loop_i,
   input  logic [SEL_W-1:0]  sel_i,
   output logic [ADDR_W-1:0] rom_addr_o,
   output logic              rom_rd_o,
   input  logic [NOTE_W-1:0] rom_note_i,
   input  logic [BEAT_W-1:0] rom_beat_i,
   output logic [NOTE_W-1:0] note_code_o,
   output logic              tone_en_o,
   output logic              playing_o,
   output logic              done_o
);
   localparam int SEG_W = ADDR_W - SEL_W;
   localparam logic [CNT_W-1:0] UNIT_LAST = CNT_W'(UNIT_CYC - 1);
   localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYC > 0 ? GAP_CYC - 1 : 0);
   typedef enum logic [2:0] {IDLE, FETCH, LOAD, PLAY, GAP, DONE} state_t;
   state_t state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [SEL_W-1:0] sel_q, sel_d;
   logic [NOTE_W-1:0] note_q, note_d;
   logic [BEAT_W-1:0] beat_q, beat_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic rd_q, rd_d, tone_q, tone_d, play_q, play_d, done_q, done_d;
   logic hold, adv, fin;
   always_comb begin
      state_d = state_q;
      addr_d = addr_q;
      sel_d = sel_q;
      note_d = note_q;
      beat_d = beat_q;
      cnt_d = cnt_q;
      done_d = 1'b0;
      adv = 1'b0;
      fin = 1'b0;
      hold = (state_q == PLAY || state_q == GAP) && pause_i;
      if (state_q != IDLE && !en_i) begin
         state_d = IDLE;
         note_d = '0;
      end else if (state_q != IDLE && sel_i != sel_q) begin
         state_d = FETCH;
         addr_d = {sel_i, {SEG_W{1'b0}}};
         sel_d = sel_i;
         beat_d = '0;
         cnt_d = '0;
      end else if (!hold) begin
         case (state_q)
            IDLE: if (en_i) begin
               state_d = FETCH;
               addr_d = {sel_i, {SEG_W{1'b0}}};
               sel_d = sel_i;
            end
            FETCH: state_d = LOAD;
            LOAD: if (rom_beat_i == '0) fin = 1'b1;
            else begin
               state_d = PLAY;
               note_d = rom_note_i;
               beat_d = rom_beat_i;
               cnt_d = '0;
            end
            PLAY: if (cnt_q == UNIT_LAST) begin
               cnt_d = '0;
               beat_d = beat_q - BEAT_W'(1);
               if (beat_q == BEAT_W'(1)) begin
                  state_d = GAP;
                  adv = GAP_CYC == 0;
               end
            end else cnt_d = cnt_q + CNT_W'(1);
            GAP: if (cnt_q == GAP_LAST) adv = 1'b1;
            else cnt_d = cnt_q + CNT_W'(1);
            DONE: ;
            default: state_d = IDLE;
         endcase
         // the last slot of a segment doubles as an implicit end marker
         if (adv && !(&addr_q[SEG_W-1:0])) begin
            state_d = FETCH;
            addr_d = addr_q + ADDR_W'(1);
         end
         fin = fin || (adv && (&addr_q[SEG_W-1:0]));
         if (fin) begin
            state_d = loop_i ? FETCH : DONE;
            addr_d = loop_i ? {sel_q, {SEG_W{1'b0}}} : addr_q;
            done_d = !loop_i;
         end
      end
      rd_d = state_d == FETCH;
      play_d = state_d inside {FETCH, LOAD, PLAY, GAP};
      tone_d = state_d == PLAY && note_d != '0 && !pause_i;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         addr_q <= '0;
         sel_q <= '0;
         note_q <= '0;
         beat_q <= '0;
         cnt_q <= '0;
         rd_q <= 1'b0;
         tone_q <= 1'b0;
         play_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q <= addr_d;
         sel_q <= sel_d;
         note_q <= note_d;
         beat_q <= beat_d;
         cnt_q <= cnt_d;
         rd_q <= rd_d;
         tone_q <= tone_d;
         play_q <= play_d;
         done_q <= done_d;
      end
   end
   assign rom_addr_o = addr_q;
   assign rom_rd_o = rd_q;
   assign note_code_o = note_q;
   assign tone_en_o = tone_q;
   assign playing_o = play_q;
   assign done_o = done_q;
endmodule

// File: tb/tb_bzmusic_seq.sv
// tb_bzmusic_seq: per-cycle trace check of bzmusic_seq against a note-list timeline model
module tb_bzmusic_seq;
   localparam int UNIT = 4;
   localparam int GAP = 2;
   logic clk = 1'b0;
   logic rst, en, pause, loop, watch;
   logic [1:0] sel;
   logic [7:0] rom_addr;
   logic rom_rd, tone_en, playing, done;
   logic [4:0] note_code;
   logic [8:0] rom [256];
   logic [8:0] rom_q = '0;
   logic [16:0] obs, last_e;
   logic [16:0] exp_q [$];
   int tests = 0, fails = 0, bad80 = 0;
   always #5 clk = ~clk;
   bzmusic_seq #(.UNIT_CYC(UNIT), .GAP_CYC(GAP), .CNT_W(4)) dut (
      .clk(clk), .rst(rst), .en_i(en), .pause_i(pause), .loop_i(loop), .sel_i(sel),
      .rom_addr_o(rom_addr), .rom_rd_o(rom_rd), .rom_note_i(rom_q[8:4]), .rom_beat_i(rom_q[3:0]),
      .note_code_o(note_code), .tone_en_o(tone_en), .playing_o(playing), .done_o(done)
   );
   always @(posedge clk) if (rom_rd) rom_q <= rom[rom_addr];
   always @(posedge clk) if (watch && rom_rd && rom_addr == 8'h80) bad80 <= bad80 + 1;
   assign obs = {rom_rd, rom_addr, tone_en, note_code, playing, done};
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   task automatic chk(input string tag, input logic [16:0] e);
      tests++;
      assert (obs === e) else begin
         fails++;
         $error("FAIL %s: observed {rd,addr,tone,note,play,done}=%h expected %h", tag, obs, e);
      end
   endtask
   function automatic void push(input logic rd, input logic [7:0] a, input logic t, input logic [4:0] n, input logic p, input logic d);
      exp_q.push_back({rd, a, t, n, p, d});
   endfunction
   // expected output timeline: FETCH, LOAD, beat*UNIT play cycles, GAP silent cycles per note
   task automatic model(input int s, input bit lm, input int loops, input int tail, input logic [4:0] n0);
      int a, lp;
      logic [4:0] nl, n;
      logic [3:0] b;
      bit fin;
      a = s * 64;
      lp = loops;
      nl = n0;
      exp_q.delete();
      forever begin
         push(1, 8'(a), 0, nl, 1, 0);
         push(0, 8'(a), 0, nl, 1, 0);
         {n, b} = rom[a];
         fin = b == 0;
         if (!fin) begin
            nl = n;
            repeat (int'(b) * UNIT) push(0, 8'(a), n != 0, nl, 1, 0);
            repeat (GAP) push(0, 8'(a), 0, nl, 1, 0);
            fin = a % 64 == 63;
            if (!fin) a++;
         end
         if (fin) begin
            if (!lm) begin
               push(0, 8'(a), 0, nl, 0, 1);
               repeat (tail) push(0, 8'(a), 0, nl, 0, 0);
               break;
            end
            a = s * 64;
            if (lp == 0) begin
               push(1, 8'(a), 0, nl, 1, 0);
               break;
            end
            lp--;
         end
      end
   endtask
   task automatic run(input string tag, input int n);
      for (int i = 0; i < n && exp_q.size() > 0; i++) begin
         step();
         last_e = exp_q.pop_front();
         chk(tag, last_e);
      end
   endtask
   task automatic drop_en(input string tag);
      en = 1'b0;
      step();
      chk(tag, last_e & 17'h0FF00);
   endtask
   task automatic fill_rand(input int s);
      int len;
      len = $urandom_range(0, 6);
      for (int i = 0; i < len; i++)
         rom[s * 64 + i] = {($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31)), 4'($urandom_range(1, 3))};
      rom[s * 64 + len] = {5'($urandom_range(0, 31)), 4'd0};
   endtask
   initial begin
      rst = 1'b1; en = 1'b0; pause = 1'b0; loop = 1'b0; sel = 2'd0; watch = 1'b0;
      for (int i = 0; i < 256; i++) rom[i] = '0;
      rom[8'h40] = {5'd5, 4'd2};
      rom[8'h41] = {5'd0, 4'd1};
      rom[8'h42] = {5'd9, 4'd0};
      step();
      chk("reset", '0);
      rst = 1'b0;
      step();
      chk("idle", '0);
      sel = 2'd1; en = 1'b1;
      model(1, 0, 0, 3, 5'd0);
      run("song1", 100000);
      drop_en("song1_idle");
      loop = 1'b1; en = 1'b1;
      model(1, 1, 2, 0, 5'd0);
      run("loop3", 100000);
      drop_en("loop_idle");
      loop = 1'b0; en = 1'b1;
      model(1, 0, 0, 2, 5'd0);
      run("pre_pause", 6);
      pause = 1'b1;
      repeat (5) begin
         step();
         chk("paused", last_e & ~17'h00080);
      end
      pause = 1'b0;
      run("post_pause", 100000);
      drop_en("pause_idle");
      fill_rand(2);
      en = 1'b1;
      model(1, 0, 0, 0, 5'd0);
      run("pre_sel", 5);
      sel = 2'd2;
      model(2, 0, 0, 2, 5'd5);
      run("sel_song2", 100000);
      drop_en("sel_idle");
      for (int r = 0; r < 4; r++) begin
         bit lm;
         lm = 1'($urandom_range(0, 1));
         fill_rand(3);
         sel = 2'd3; loop = lm; en = 1'b1;
         model(3, lm, lm ? 1 : 0, 2, 5'd0);
         run("rand_song", 100000);
         drop_en("rand_idle");
      end
      sel = 2'd1; loop = 1'b0; en = 1'b1;
      model(1, 0, 0, 0, 5'd0);
      run("pre_gap_drop", 11);
      en = 1'b0;
      step();
      chk("en_drop_gap", last_e & 17'h0FF00);
      en = 1'b1;
      model(1, 0, 0, 0, 5'd0);
      run("pre_rst", 5);
      rst = 1'b1;
      step();
      chk("rst_play", '0);
      rst = 1'b0; en = 1'b0;
      step();
      chk("post_rst", '0);
      for (int i = 0; i < 64; i++) rom[64 + i] = {5'($urandom_range(1, 31)), 4'd1};
      watch = 1'b1; en = 1'b1;
      model(1, 0, 0, 2, 5'd0);
      run("seg_full", 100000);
      drop_en("seg_idle");
      loop = 1'b1; en = 1'b1;
      model(1, 1, 0, 0, 5'd0);
      run("seg_loop", 100000);
      drop_en("seg_loop_idle");
      watch = 1'b0;
      step();
      tests++;
      assert (bad80 === 0) else begin
         fails++;
         $error("FAIL seg_no_0x80: observed %0d reads expected 0", bad80);
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
